// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection, flush and perf counters
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [9:0]        id_ctrl,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              flush,
    output logic              ex_valid,
    output logic [9:0]        ex_ctrl,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic              pc_write,
    output logic              ifid_write,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic rt_used;
    logic load_use;
    logic hazard;
    logic squash;

    // R-type, sw and beq are the only decoded forms that read rt
    assign rt_used  = id_ctrl[9] | id_ctrl[4] | id_ctrl[3];
    assign load_use = id_valid & ex_valid & ex_ctrl[5] & (ex_rt != '0) &
                      ((ex_rt == id_rs) | (rt_used & (ex_rt == id_rt)));
    assign hazard   = load_use & ~flush;
    assign squash   = hazard | flush | ~id_valid;

    assign pc_write   = ~hazard;
    assign ifid_write = ~hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_pc4    <= '0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_imm    <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            ex_valid  <= ~squash;
            ex_ctrl   <= squash ? 10'd0 : id_ctrl;
            ex_pc4    <= id_pc4;
            ex_rdata1 <= id_rdata1;
            ex_rdata2 <= id_rdata2;
            ex_imm    <= id_imm;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_rd     <= id_rd;
            if (hazard && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage with directed hazard/flush/saturation vectors
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [9:0]  id_ctrl = '0;
    logic [31:0] id_pc4 = '0, id_rdata1 = '0, id_rdata2 = '0, id_imm = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        flush = 1'b0;

    logic        ex_valid, pc_write, ifid_write;
    logic [9:0]  ex_ctrl;
    logic [31:0] ex_pc4, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_valid, s_pc_write, s_ifid_write;
    logic [9:0]  s_ctrl;
    logic [31:0] s_pc4, s_rdata1, s_rdata2, s_imm;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc4(id_pc4), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc4(id_pc4), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .ex_valid(s_valid), .ex_ctrl(s_ctrl), .ex_pc4(s_pc4),
        .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2), .ex_imm(s_imm),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic        pw;
        logic        v;
        logic [9:0]  c;
        logic [31:0] d1;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [1:0]  fs;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // drive one decode slot at the negedge and queue the hand-computed result
    task automatic step(input logic v, input logic [9:0] c, input logic [31:0] d1,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic fl, input exp_t e);
        @(negedge clk);
        id_valid  = v;
        id_ctrl   = c;
        id_rdata1 = d1;
        id_rdata2 = ~d1;
        id_imm    = d1 + 32'h100;
        id_pc4    = d1 + 32'h4;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        flush     = fl;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic pw_s, iw_s;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                pw_s = pc_write;
                iw_s = ifid_write;
                @(posedge clk);
                #1;
                check("pc_write",   {31'd0, pw_s},     {31'd0, e.pw});
                check("ifid_write", {31'd0, iw_s},     {31'd0, e.pw});
                check("ex_valid",   {31'd0, ex_valid}, {31'd0, e.v});
                check("ex_ctrl",    {22'd0, ex_ctrl},  {22'd0, e.c});
                check("ex_rdata1",  ex_rdata1,         e.d1);
                check("ex_rdata2",  ex_rdata2,         ~e.d1);
                check("ex_rt",      {27'd0, ex_rt},    {27'd0, e.rt});
                check("ex_rd",      {27'd0, ex_rd},    {27'd0, e.rd});
                check("stall_cnt",  {16'd0, stall_cnt}, {16'd0, e.sc});
                check("flush_cnt",  {16'd0, flush_cnt}, {16'd0, e.fc});
                check("flush_sat",  {30'd0, s_flush_cnt}, {30'd0, e.fs});
            end
        end
    end

    task automatic drain();
        int budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        repeat (2) @(posedge clk);
        if (exp_q.size() > 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        check({tag, "_ctrl"},  {22'd0, ex_ctrl}, 32'd0);
        check({tag, "_data"},  ex_rdata1 | ex_rdata2 | ex_imm | ex_pc4, 32'd0);
        check({tag, "_spec"},  {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
        check({tag, "_cnt"},   {stall_cnt, flush_cnt}, 32'd0);
        check({tag, "_pcw"},   {30'd0, pc_write, ifid_write}, 32'd3);
    endtask

    initial begin : driver
        // reset with random inputs applied and no clock edge inside the window
        id_valid  = 1'b1;
        id_ctrl   = 10'($urandom);
        id_rdata1 = $urandom;
        id_rs     = 5'($urandom);
        #1;
        check_reset("rst0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //       v   ctrl     d1      rs  rt  rd  fl       pw v  ctrl    d1     rt  rd  sc fc fs
        step(1, 10'h244, 32'h11, 1, 2, 5, 0, '{1, 1, 10'h244, 32'h11, 2, 5, 0, 0, 0});
        step(1, 10'h1E0, 32'h33, 1, 8, 0, 0, '{1, 1, 10'h1E0, 32'h33, 8, 0, 0, 0, 0});
        step(1, 10'h244, 32'h44, 4, 8, 9, 0, '{0, 0, 10'h000, 32'h44, 8, 9, 1, 0, 0});
        step(1, 10'h244, 32'h44, 4, 8, 9, 0, '{1, 1, 10'h244, 32'h44, 8, 9, 1, 0, 0});
        step(1, 10'h1E0, 32'h55, 1, 0, 0, 0, '{1, 1, 10'h1E0, 32'h55, 0, 0, 1, 0, 0});
        step(1, 10'h244, 32'h66, 0, 0, 3, 0, '{1, 1, 10'h244, 32'h66, 0, 3, 1, 0, 0});
        step(1, 10'h1E0, 32'h77, 2, 8, 0, 0, '{1, 1, 10'h1E0, 32'h77, 8, 0, 1, 0, 0});
        step(1, 10'h141, 32'h88, 3, 8, 0, 0, '{1, 1, 10'h141, 32'h88, 8, 0, 1, 0, 0});
        step(1, 10'h1E0, 32'h99, 2, 8, 0, 0, '{1, 1, 10'h1E0, 32'h99, 8, 0, 1, 0, 0});
        step(1, 10'h244, 32'hAA, 8, 1, 4, 1, '{1, 0, 10'h000, 32'hAA, 1, 4, 1, 1, 1});
        step(0, 10'h3FF, 32'hBB, 5, 2, 6, 0, '{1, 0, 10'h000, 32'hBB, 2, 6, 1, 1, 1});
        step(1, 10'h1E0, 32'hCC, 1, 7, 0, 0, '{1, 1, 10'h1E0, 32'hCC, 7, 0, 1, 1, 1});
        drain();

        // hazard held in decode, then reset lands mid-stall
        @(negedge clk);
        id_valid = 1'b1;
        id_ctrl  = 10'h010;
        id_rs    = 5'd3;
        id_rt    = 5'd7;
        flush    = 1'b0;
        #2;
        check("midstall_pcw", {30'd0, pc_write, ifid_write}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset("rst1");
        @(negedge clk);
        rst_n = 1'b1;

        //       v   ctrl     d1      rs  rt  rd  fl       pw v  ctrl    d1     rt  rd  sc fc fs
        step(1, 10'h244, 32'h01, 1, 2, 3, 1, '{1, 0, 10'h000, 32'h01, 2, 3, 0, 1, 1});
        step(1, 10'h244, 32'h02, 1, 2, 3, 1, '{1, 0, 10'h000, 32'h02, 2, 3, 0, 2, 2});
        step(1, 10'h244, 32'h03, 1, 2, 3, 1, '{1, 0, 10'h000, 32'h03, 2, 3, 0, 3, 3});
        step(1, 10'h244, 32'h04, 1, 2, 3, 1, '{1, 0, 10'h000, 32'h04, 2, 3, 0, 4, 3});
        step(1, 10'h244, 32'h05, 1, 2, 3, 1, '{1, 0, 10'h000, 32'h05, 2, 3, 0, 5, 3});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
